// File: rtl/pea_pkg.sv
// pea_pkg: shared types and constants for the PE-array divider-sharing controller.
//   div_share_state_e : controller FSM states.
//   N_DIV_REQ         : default number of PEs sharing one divider.
//   DIV_ZERO_RES      : fill bit for a divide-by-zero quotient (replicated to all ones).
package pea_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } div_share_state_e;

    localparam int unsigned N_DIV_REQ = 4;

    // Quotient of x/0 is all ones: -1 for DIV, 2^N-1 for DIVU.
    localparam logic DIV_ZERO_RES = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin find-first.
//   req_i  : request vector
//   ptr_i  : index where the search starts (wraps past N_REQ-1 to 0)
//   gnt_o  : one-hot grant of the first requester found
//   idx_o  : index of that requester
//   any_o  : at least one request present
module rr_pick
    import pea_pkg::*;
#(
    parameter int unsigned N_REQ = N_DIV_REQ,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = IDX_W'((32'(ptr_i) + i) % N_REQ);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one external iterative divider among N_REQ PEs.
// Grants requesters round-robin, runs one division at a time through the divider's
// valid/ready handshake, returns the quotient to the granted PE only, and answers
// divide-by-zero locally without touching the divider.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   flush_i                 : synchronous abort of the current operation
//   req_*                   : per-PE request handshake and packed operands
//   resp_*                  : per-PE response handshake, shared quotient bus
//   div_*                   : handshake and operands to/from the external divider
//   busy_o, op_cnt_o        : not-idle status, saturating completed-op counter
module div_share_ctrl
    import pea_pkg::*;
#(
    parameter int unsigned N_REQ  = N_DIV_REQ,
    parameter int unsigned N_BITS = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ-1:0]        req_signed_i,
    input  logic [N_REQ*N_BITS-1:0] req_a_i,
    input  logic [N_REQ*N_BITS-1:0] req_b_i,
    output logic [N_REQ-1:0]        resp_valid_o,
    input  logic [N_REQ-1:0]        resp_ready_i,
    output logic [N_BITS-1:0]       resp_data_o,
    output logic                    div_in_valid_o,
    input  logic                    div_in_ready_i,
    output logic [N_BITS-1:0]       div_a_o,
    output logic [N_BITS-1:0]       div_b_o,
    output logic                    div_signed_o,
    input  logic                    div_out_valid_i,
    output logic                    div_out_ready_o,
    input  logic [N_BITS-1:0]       div_res_i,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        op_cnt_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    div_share_state_e  state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  id_q, id_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic              signed_q, signed_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [N_BITS-1:0] a_sel, b_sel;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign a_sel = req_a_i[N_BITS*pick_idx +: N_BITS];
    assign b_sel = req_b_i[N_BITS*pick_idx +: N_BITS];

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        id_d            = id_q;
        a_d             = a_q;
        b_d             = b_q;
        signed_d        = signed_q;
        result_d        = result_q;
        cnt_d           = cnt_q;
        req_ready_o     = '0;
        resp_valid_o    = '0;
        resp_data_o     = '0;
        div_in_valid_o  = 1'b0;
        div_out_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!flush_i && pick_any) begin
                    req_ready_o = pick_gnt;
                    id_d        = pick_idx;
                    a_d         = a_sel;
                    b_d         = b_sel;
                    signed_d    = req_signed_i[pick_idx];
                    if (b_sel == '0) begin
                        result_d = {N_BITS{DIV_ZERO_RES}};
                        state_d  = StResp;
                    end else begin
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                div_in_valid_o = 1'b1;
                if (flush_i) begin
                    state_d = StIdle;
                end else if (div_in_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                div_out_ready_o = 1'b1;
                if (flush_i) begin
                    // A result arriving with the flush is already absorbed by this
                    // handshake; draining for it would wait forever.
                    state_d = div_out_valid_i ? StIdle : StDrain;
                end else if (div_out_valid_i) begin
                    result_d = div_res_i;
                    state_d  = StResp;
                end
            end
            StResp: begin
                resp_valid_o[id_q] = 1'b1;
                resp_data_o        = result_q;
                if (flush_i) begin
                    state_d = StIdle;
                end else if (resp_ready_i[id_q]) begin
                    state_d = StIdle;
                    ptr_d   = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                div_out_ready_o = 1'b1;
                if (div_out_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign div_signed_o = signed_q;
    assign busy_o       = (state_q != StIdle);
    assign op_cnt_o     = cnt_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed vectors, expected responses queued at issue
// time and popped by a monitor on every response handshake.
module tb_div_share_ctrl;

    localparam int NR = 4;
    localparam int NB = 32;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_signed = '0;
    logic [NR*NB-1:0] req_a = '0;
    logic [NR*NB-1:0] req_b = '0;
    logic [NR-1:0]    resp_valid;
    logic [NR-1:0]    resp_ready = '1;
    logic [NB-1:0]    resp_data;
    logic             div_in_valid, div_in_ready;
    logic [NB-1:0]    div_a, div_b;
    logic             div_signed;
    logic             div_out_valid, div_out_ready;
    logic [NB-1:0]    div_res;
    logic             busy;
    logic [CW-1:0]    op_cnt;

    typedef struct {
        int            pe;
        logic [NB-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_resp = 0;
    int   n_div_in = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(
        .N_REQ  (NR),
        .N_BITS (NB),
        .CNT_W  (CW)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_signed_i    (req_signed),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_data_o     (resp_data),
        .div_in_valid_o  (div_in_valid),
        .div_in_ready_i  (div_in_ready),
        .div_a_o         (div_a),
        .div_b_o         (div_b),
        .div_signed_o    (div_signed),
        .div_out_valid_i (div_out_valid),
        .div_out_ready_o (div_out_ready),
        .div_res_i       (div_res),
        .busy_o          (busy),
        .op_cnt_o        (op_cnt)
    );

    // Behavioural divider: fixed latency after accept, single outstanding op.
    logic          dv_busy;
    int            dv_cnt;
    logic [NB-1:0] dv_res;
    int            dv_lat = 5;
    logic          dv_hold = 1'b0;

    assign div_in_ready  = !dv_busy && !dv_hold;
    assign div_out_valid = dv_busy && (dv_cnt == 0);
    assign div_res       = div_out_valid ? dv_res : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
            dv_res  <= '0;
        end else if (!dv_busy) begin
            if (div_in_valid && div_in_ready) begin
                dv_busy <= 1'b1;
                dv_cnt  <= dv_lat;
                dv_res  <= div_signed ? NB'($signed(div_a) / $signed(div_b)) : div_a / div_b;
            end
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
        end else if (div_out_ready) begin
            dv_busy <= 1'b0;
        end
    end

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_in_valid) n_div_in++;
            for (int k = 0; k < NR; k++) begin
                if (resp_valid[k] && resp_ready[k]) begin
                    n_checks++;
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL resp_unexpected: got pe %0d data %h, required no response",
                                 k, resp_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.pe != k || mon_e.data != resp_data) begin
                            n_errors++;
                            $display("FAIL resp: got pe %0d data %h, required pe %0d data %h",
                                     k, resp_data, mon_e.pe, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, required event", name);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ctrl"}, 64'({req_ready, resp_valid, div_in_valid, div_out_ready,
                                   div_signed, busy, op_cnt}), 64'd0);
        check({pfx, "_data"}, {resp_data, div_a}, 64'd0);
        check({pfx, "_divb"}, 64'(div_b), 64'd0);
    endtask

    task automatic set_req(input int pe, input bit sg, input logic [NB-1:0] a,
                           input logic [NB-1:0] b);
        req_valid[pe]         = 1'b1;
        req_signed[pe]        = sg;
        req_a[pe*NB +: NB]    = a;
        req_b[pe*NB +: NB]    = b;
    endtask

    task automatic push(input int pe, input logic [NB-1:0] data);
        exp_t e;
        e.pe   = pe;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits for the grant to PE pe, then drops its request just after the accept edge.
    task automatic wait_grant(input int pe);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[pe]) ok = 1'b1;
        end
        if (!ok) fail_timeout($sformatf("grant_pe%0d", pe));
        @(posedge clk);
        #1;
        req_valid[pe] = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (n_resp >= target) ok = 1'b1;
        end
        if (!ok) fail_timeout("resp_count");
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;

        // Reset state
        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: PE2 DIVU 100/7 = 14, latency 5
        dv_lat = 5;
        set_req(2, 1'b0, 32'd100, 32'd7);
        push(2, 32'd14);
        #1;
        check("t1_req_ready", 64'(req_ready), 64'b0100);
        wait_grant(2);
        wait_resp(1);
        check("t1_op_cnt", 64'(op_cnt), 64'd1);

        // T2: all PEs from reset, grant order 0,1,2,3,0
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = n_resp;
        set_req(0, 1'b0, 32'd50, 32'd5);
        set_req(1, 1'b1, 32'hFFFF_FFE2, 32'd6);
        set_req(2, 1'b0, 32'd81, 32'd9);
        set_req(3, 1'b1, 32'd77, 32'hFFFF_FFF9);
        push(0, 32'd10);
        push(1, 32'hFFFF_FFFB);
        push(2, 32'd9);
        push(3, 32'hFFFF_FFF5);
        push(0, 32'd10);
        wait_resp(base + 5);
        req_valid = '0;
        check("t2_op_cnt", 64'(op_cnt), 64'd5);

        // T3: PE1 DIV -20/0 answered locally
        tick(1);
        base = n_div_in;
        set_req(1, 1'b1, 32'hFFFF_FFEC, 32'd0);
        push(1, 32'hFFFF_FFFF);
        wait_grant(1);
        check("t3_resp_valid", 64'(resp_valid), 64'b0010);
        check("t3_resp_data", 64'(resp_data), 64'hFFFF_FFFF);
        wait_resp(n_resp + 1);
        check("t3_no_div_issue", 64'(n_div_in - base), 64'd0);
        check("t3_op_cnt", 64'(op_cnt), 64'd6);

        // T4: PE0 DIV -21/4 = -5, response held for 3 cycles
        tick(1);
        base = n_resp;
        resp_ready[0] = 1'b0;
        set_req(0, 1'b1, 32'hFFFF_FFEB, 32'd4);
        push(0, 32'hFFFF_FFFB);
        wait_grant(0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (resp_valid[0]) ok = 1'b1;
            else tick(1);
        end
        if (!ok) fail_timeout("t4_resp_valid");
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 64'(resp_valid), 64'b0001);
            check("t4_hold_data", 64'(resp_data), 64'hFFFF_FFFB);
            tick(1);
        end
        resp_ready[0] = 1'b1;
        wait_resp(base + 1);
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_op_cnt", 64'(op_cnt), 64'd7);
        // Pointer now 1: PE1 beats PE0
        set_req(0, 1'b0, 32'd8, 32'd2);
        set_req(1, 1'b0, 32'd9, 32'd3);
        #1;
        check("t4_ptr_grant", 64'(req_ready), 64'b0010);
        push(1, 32'd3);
        push(0, 32'd4);
        wait_grant(1);
        wait_grant(0);
        wait_resp(base + 3);
        check("t4_op_cnt2", 64'(op_cnt), 64'd9);

        // T5: flush in WAIT, divider result drained
        tick(1);
        dv_lat = 3;
        base = n_resp;
        set_req(3, 1'b0, 32'd63, 32'd7);
        wait_grant(3);
        tick(1);
        check("t5_wait", 64'({busy, div_out_ready, div_in_valid}), 64'b110);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t5_drain", 64'({busy, div_out_ready}), 64'b11);
        tick(6);
        check("t5_idle", 64'({busy, dv_busy}), 64'd0);
        check("t5_no_resp", 64'(n_resp - base), 64'd0);
        check("t5_op_cnt", 64'(op_cnt), 64'd9);
        set_req(2, 1'b0, 32'd20, 32'd4);
        push(2, 32'd5);
        wait_grant(2);
        wait_resp(base + 1);
        check("t5_op_cnt2", 64'(op_cnt), 64'd10);

        // T6: reset during ISSUE
        tick(1);
        dv_hold = 1'b1;
        set_req(3, 1'b0, 32'd10, 32'd2);
        wait_grant(3);
        check("t6_issue", 64'({div_in_valid, div_a}), {31'd0, 1'b1, 32'd10});
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dv_hold = 1'b0;
        base = n_resp;
        set_req(1, 1'b0, 32'd12, 32'd4);
        set_req(3, 1'b0, 32'd10, 32'd2);
        #1;
        check("t6_ptr_grant", 64'(req_ready), 64'b0010);
        push(1, 32'd3);
        push(3, 32'd5);
        wait_grant(1);
        wait_grant(3);
        wait_resp(base + 2);
        check("t6_op_cnt", 64'(op_cnt), 64'd2);

        tick(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
